// File: rtl/sr_pulse_gen_pkg.sv
// Shared definitions for the pushbutton-to-SR-pulse generator.
//   DebounceCyclesDefault : default debounce hold time in synced clock cycles
//   cnt_width()           : width of a debounce counter for a given hold time
//   arb_e                 : per-cycle arbitration outcome, encoded {rst_req, set_req}
package sr_pulse_gen_pkg;

  localparam int unsigned DebounceCyclesDefault = 4;

  // The counter only ever reaches DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  // Floor of 1 keeps the vector legal for the smallest hold time.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  typedef enum logic [1:0] {
    ArbIdle     = 2'b00,
    ArbSet      = 2'b01,
    ArbRst      = 2'b10,
    ArbConflict = 2'b11
  } arb_e;

endpackage

// File: rtl/sr_debounce.sv
// One pushbutton channel: two-flop synchronizer, debounce counter and
// rising-edge detect of the accepted (stable) level.
//   clk  : clock
//   rst  : synchronous active-high reset
//   btn  : raw asynchronous bouncing button
//   rise : one-cycle request on each 0->1 change of the stable level
module sr_debounce
  import sr_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic            prev_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Any cycle where the synced level agrees with the stable level restarts the
  // count, so a level must differ for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign rise = stable_q & ~prev_q;

endmodule

// File: rtl/sr_pulse_gen.sv
// Turns two bouncing pushbuttons into clean one-cycle S/R pulses for a
// downstream SR latch, suppressing simultaneous requests.
//   clk      : clock
//   rst      : synchronous active-high reset
//   btn_set  : raw set button
//   btn_rst  : raw reset button
//   S        : registered one-cycle set pulse
//   R        : registered one-cycle reset pulse
//   conflict : registered one-cycle flag for a suppressed set+reset request
//   q_model  : registered copy of the latch state implied by issued pulses
module sr_pulse_gen
  import sr_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic S,
  output logic R,
  output logic conflict,
  output logic q_model
);

  logic set_req;
  logic rst_req;
  arb_e arb;

  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;
  logic q_q, q_d;

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_set),
    .rise (set_req)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_rst),
    .rise (rst_req)
  );

  assign arb = arb_e'({rst_req, set_req});

  // q_model is registered alongside S/R so it changes in the same cycle the
  // pulse is visible downstream.
  always_comb begin
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    q_d        = q_q;
    unique case (arb)
      ArbSet: begin
        s_d = 1'b1;
        q_d = 1'b1;
      end
      ArbRst: begin
        r_d = 1'b1;
        q_d = 1'b0;
      end
      ArbConflict: begin
        conflict_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      q_q        <= q_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conflict_q;
  assign q_model  = q_q;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed bench for sr_pulse_gen with DEBOUNCE_CYCLES = 4, driving a
// behavioural SR latch whose Q is compared against q_model.
module tb_sr_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic S, R, conflict, q_model;

  int n_vec = 0;
  int n_miss = 0;

  sr_pulse_gen #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_set  (btn_set),
    .btn_rst  (btn_rst),
    .S        (S),
    .R        (R),
    .conflict (conflict),
    .q_model  (q_model)
  );

  always #5 clk = ~clk;

  // Downstream latch; its state is only meaningful once a pulse has hit it
  // since the last reset of the generator.
  logic latch_q = 1'b0;
  logic latch_known = 1'b0;
  always @(S or R or rst) begin
    if (rst) latch_known = 1'b0;
    else if (S) begin
      latch_q = 1'b1;
      latch_known = 1'b1;
    end else if (R) begin
      latch_q = 1'b0;
      latch_known = 1'b1;
    end
  end

  typedef struct packed {
    logic r;
    logic bs;
    logic br;
    logic es;
    logic er;
    logic ec;
    logic eq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic bs, input logic br,
                     input logic es, input logic er, input logic ec, input logic eq);
    for (int i = 0; i < n; i++) vecs.push_back('{r, bs, br, es, er, ec, eq});
  endtask

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @vec %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  initial begin
    int lat;
    int extra;
    bit found;

    // Each record: inputs held before an edge, outputs expected just after it.
    // reset 3 cycles, then idle
    add(3,  1, 0, 0,  0, 0, 0, 0);
    add(20, 0, 0, 0,  0, 0, 0, 0);
    // set held 20 cycles: single S after edge 7
    add(6,  0, 1, 0,  0, 0, 0, 0);
    add(1,  0, 1, 0,  1, 0, 0, 1);
    add(13, 0, 1, 0,  0, 0, 0, 1);
    add(12, 0, 0, 0,  0, 0, 0, 1);
    // reset button chattering every cycle: filtered out
    for (int i = 0; i < 4; i++) begin
      add(1, 0, 0, 1,  0, 0, 0, 1);
      add(1, 0, 0, 0,  0, 0, 0, 1);
    end
    add(12, 0, 0, 0,  0, 0, 0, 1);
    // both buttons together: conflict only
    add(6,  0, 1, 1,  0, 0, 0, 1);
    add(1,  0, 1, 1,  0, 0, 1, 1);
    add(3,  0, 1, 1,  0, 0, 0, 1);
    add(12, 0, 0, 0,  0, 0, 0, 1);
    // reset press clears q
    add(6,  0, 0, 1,  0, 0, 0, 1);
    add(1,  0, 0, 1,  0, 1, 0, 0);
    add(1,  0, 0, 1,  0, 0, 0, 0);
    add(12, 0, 0, 0,  0, 0, 0, 0);
    // set then reset press, rising edges 15 cycles apart
    add(6,  0, 1, 0,  0, 0, 0, 0);
    add(1,  0, 1, 0,  1, 0, 0, 1);
    add(1,  0, 1, 0,  0, 0, 0, 1);
    add(7,  0, 0, 0,  0, 0, 0, 1);
    add(6,  0, 0, 1,  0, 0, 0, 1);
    add(1,  0, 0, 1,  0, 1, 0, 0);
    add(1,  0, 0, 1,  0, 0, 0, 0);
    add(12, 0, 0, 0,  0, 0, 0, 0);
    // 3-cycle glitch (one short of the hold time): ignored
    add(3,  0, 1, 0,  0, 0, 0, 0);
    add(12, 0, 0, 0,  0, 0, 0, 0);
    // 4-cycle press (exactly the hold time): accepted
    add(4,  0, 1, 0,  0, 0, 0, 0);
    add(2,  0, 0, 0,  0, 0, 0, 0);
    add(1,  0, 0, 0,  1, 0, 0, 1);
    add(12, 0, 0, 0,  0, 0, 0, 1);
    // reset mid-debounce discards the partial count
    add(4,  0, 1, 0,  0, 0, 0, 1);
    add(1,  1, 0, 0,  0, 0, 0, 0);
    add(15, 0, 0, 0,  0, 0, 0, 0);
    // set high 2 cycles, 1-cycle reset, set kept high: S 7 edges after release
    add(2,  0, 1, 0,  0, 0, 0, 0);
    add(1,  1, 1, 0,  0, 0, 0, 0);
    add(6,  0, 1, 0,  0, 0, 0, 0);
    add(1,  0, 1, 0,  1, 0, 0, 1);
    add(10, 0, 1, 0,  0, 0, 0, 1);
    add(12, 0, 0, 0,  0, 0, 0, 1);

    foreach (vecs[i]) begin
      rst     = vecs[i].r;
      btn_set = vecs[i].bs;
      btn_rst = vecs[i].br;
      @(posedge clk);
      #1;
      n_vec++;
      chk("S", i, S, vecs[i].es);
      chk("R", i, R, vecs[i].er);
      chk("conflict", i, conflict, vecs[i].ec);
      chk("q_model", i, q_model, vecs[i].eq);
      chk("s_and_r", i, S & R, 1'b0);
      if (latch_known) chk("latch_q", i, latch_q, q_model);
    end

    // Reset button held through reset release: measure latency with a bound.
    rst     = 1'b1;
    btn_rst = 1'b1;
    btn_set = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (R) begin
        found = 1'b1;
        lat   = k;
      end
    end
    n_vec++;
    if (!found) begin
      n_miss++;
      $display("FAIL r_latency: no R pulse within 20 edges, expected at edge 7");
    end else if (lat != 7) begin
      n_miss++;
      $display("FAIL r_latency: R at edge %0d expected edge 7", lat);
    end
    n_vec++;
    chk("q_after_r", -1, q_model, 1'b0);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (R || S || conflict) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_miss++;
      $display("FAIL r_held_single: %0d extra pulse cycles expected 0", extra);
    end
    btn_rst = 1'b0;
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
